// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache (port 0)
// and the D-cache (port 1), with per-port saturating completion counters.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [CNT_W-1:0]  p0_count_o,
  output logic [CNT_W-1:0]  p1_count_o
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic [CNT_W-1:0]    p0_count_q, p0_count_d;
  logic [CNT_W-1:0]    p1_count_q, p1_count_d;

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    p0_count_d   = p0_count_q;
    p1_count_d   = p1_count_q;
    p0_ack_o     = 1'b0;
    p1_ack_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Port 0 wins when alone, or under contention if port 1 was served last.
        if (p0_enable_i && (!p1_enable_i || rr_last_q)) begin
          state_d      = StGrant0;
          rr_last_d    = 1'b0;
          mem_enable_d = 1'b1;
          mem_write_d  = p0_write_i;
          mem_addr_d   = p0_addr_i;
          mem_data_d   = p0_data_i;
        end else if (p1_enable_i) begin
          state_d      = StGrant1;
          rr_last_d    = 1'b1;
          mem_enable_d = 1'b1;
          mem_write_d  = p1_write_i;
          mem_addr_d   = p1_addr_i;
          mem_data_d   = p1_data_i;
        end
      end
      StGrant0: begin
        p0_ack_o = mem_ack_i;
        if (mem_ack_i) begin
          state_d      = StIdle;
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
          if (p0_count_q != CntMax) p0_count_d = p0_count_q + CntOne;
        end
      end
      StGrant1: begin
        p1_ack_o = mem_ack_i;
        if (mem_ack_i) begin
          state_d      = StIdle;
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
          if (p1_count_q != CntMax) p1_count_d = p1_count_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      rr_last_q    <= 1'b1;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      p0_count_q   <= '0;
      p1_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      p0_count_q   <= p0_count_d;
      p1_count_q   <= p1_count_d;
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign p0_count_o   = p0_count_q;
  assign p1_count_o   = p1_count_q;
  assign p0_data_o    = mem_data_i;
  assign p1_data_o    = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; a second instance with 4-bit counters exercises saturation
// without needing 65535 transactions.
module tb_mem_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
  logic [31:0]  p0_addr_i, p1_addr_i;
  logic [255:0] p0_data_i, p1_data_i, mem_data_i;
  logic         mem_ack_i;

  logic         p0_ack_o, p1_ack_o, mem_enable_o, mem_write_o;
  logic [255:0] p0_data_o, p1_data_o, mem_data_o;
  logic [31:0]  mem_addr_o;
  logic [15:0]  p0_count_o, p1_count_o;

  logic         s_p0_ack_o, s_p1_ack_o, s_mem_enable_o, s_mem_write_o;
  logic [255:0] s_p0_data_o, s_p1_data_o, s_mem_data_o;
  logic [31:0]  s_mem_addr_o;
  logic [3:0]   s_p0_count_o, s_p1_count_o;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] Beef   = {8{32'hDEADBEEF}};
  localparam logic [255:0] RdData = {4{64'h0123_4567_89AB_CDEF}};

  always #5 clk_i = ~clk_i;

  mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_ack_o(p0_ack_o), .p0_data_o(p0_data_o),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_ack_o(p1_ack_o), .p1_data_o(p1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .p0_count_o(p0_count_o), .p1_count_o(p1_count_o)
  );

  mem_arbiter #(.CNT_W(4)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_ack_o(s_p0_ack_o), .p0_data_o(s_p0_data_o),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_ack_o(s_p1_ack_o), .p1_data_o(s_p1_data_o),
    .mem_enable_o(s_mem_enable_o), .mem_write_o(s_mem_write_o), .mem_addr_o(s_mem_addr_o),
    .mem_data_o(s_mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .p0_count_o(s_p0_count_o), .p1_count_o(s_p1_count_o)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One granted transaction: grant edge, lat wait cycles, then a one-cycle mem_ack_i.
  task automatic txn(input logic port, input logic [31:0] addr, input int lat);
    step();
    check("grant_enable", mem_enable_o, 1'b1);
    check("grant_addr", mem_addr_o, addr);
    repeat (lat) step();
    mem_ack_i = 1'b1;
    #1;
    check("ack_p0", p0_ack_o, port == 1'b0);
    check("ack_p1", p1_ack_o, port == 1'b1);
    step();
    mem_ack_i = 1'b0;
    check("release_enable", mem_enable_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    p0_enable_i = 1'b0; p0_write_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
    p1_enable_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
    mem_data_i = '0; mem_ack_i = 1'b0;
    step(); step();
    check("rst_enable", mem_enable_o, 1'b0);
    check("rst_write", mem_write_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_data", mem_data_o, '0);
    check("rst_cnt0", p0_count_o, 16'h0);
    check("rst_cnt1", p1_count_o, 16'h0);
    rst_i = 1'b0;
    step();

    // Port 0 read, memory acks 10 cycles after mem_enable_o.
    p0_enable_i = 1'b1; p0_addr_i = 32'h0000_0400; p0_data_i = Beef;
    step();
    check("rd_enable", mem_enable_o, 1'b1);
    check("rd_write", mem_write_o, 1'b0);
    check("rd_addr", mem_addr_o, 32'h400);
    for (int i = 0; i < 9; i++) begin
      check("rd_wait_ack0", p0_ack_o, 1'b0);
      check("rd_wait_ack1", p1_ack_o, 1'b0);
      step();
    end
    mem_data_i = RdData; mem_ack_i = 1'b1;
    #1;
    check("rd_ack0", p0_ack_o, 1'b1);
    check("rd_ack1", p1_ack_o, 1'b0);
    check("rd_data", p0_data_o, RdData);
    step();
    mem_ack_i = 1'b0; p0_enable_i = 1'b0;
    check("rd_done_enable", mem_enable_o, 1'b0);
    check("rd_cnt0", p0_count_o, 16'd1);
    check("rd_cnt1", p1_count_o, 16'd0);
    step();

    // Contention straight after reset: 0,1,0,1,... with both enables held.
    rst_i = 1'b1; step(); rst_i = 1'b0; step();
    p0_enable_i = 1'b1; p0_addr_i = 32'h1000;
    p1_enable_i = 1'b1; p1_addr_i = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      txn(1'b0, 32'h1000, 2);
      if (i == 3) p0_enable_i = 1'b0;
      txn(1'b1, 32'h2000, 1);
    end
    p1_enable_i = 1'b0;
    step();
    check("rr_cnt0", p0_count_o, 16'd4);
    check("rr_cnt1", p1_count_o, 16'd4);

    // Port 1 write, enable and inputs dropped mid-transaction.
    p1_enable_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h0000_1A20; p1_data_i = Beef;
    step();
    check("wr_enable", mem_enable_o, 1'b1);
    check("wr_write", mem_write_o, 1'b1);
    check("wr_addr", mem_addr_o, 32'h1A20);
    check("wr_data", mem_data_o, Beef);
    step(); step();
    p1_enable_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = 32'h5555; p1_data_i = '0;
    step();
    check("wr_hold_enable", mem_enable_o, 1'b1);
    check("wr_hold_write", mem_write_o, 1'b1);
    check("wr_hold_addr", mem_addr_o, 32'h1A20);
    check("wr_hold_data", mem_data_o, Beef);
    mem_ack_i = 1'b1;
    #1;
    check("wr_ack1", p1_ack_o, 1'b1);
    check("wr_ack0", p0_ack_o, 1'b0);
    step();
    mem_ack_i = 1'b0;
    check("wr_done_enable", mem_enable_o, 1'b0);
    check("wr_done_write", mem_write_o, 1'b0);
    check("wr_keep_addr", mem_addr_o, 32'h1A20);
    check("wr_keep_data", mem_data_o, Beef);
    check("wr_cnt1", p1_count_o, 16'd5);

    // Stray ack while idle.
    mem_ack_i = 1'b1;
    #1;
    check("idle_ack0", p0_ack_o, 1'b0);
    check("idle_ack1", p1_ack_o, 1'b0);
    step();
    mem_ack_i = 1'b0;
    step();
    check("idle_enable", mem_enable_o, 1'b0);
    check("idle_cnt0", p0_count_o, 16'd4);
    check("idle_cnt1", p1_count_o, 16'd5);

    // Asynchronous reset during GRANT0.
    p0_enable_i = 1'b1; p0_write_i = 1'b1; p0_addr_i = 32'h3000;
    step();
    check("pre_rst_enable", mem_enable_o, 1'b1);
    p0_enable_i = 1'b0; p0_write_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("arst_enable", mem_enable_o, 1'b0);
    check("arst_write", mem_write_o, 1'b0);
    check("arst_addr", mem_addr_o, 32'h0);
    check("arst_cnt0", p0_count_o, 16'd0);
    check("arst_cnt1", p1_count_o, 16'd0);
    step();
    rst_i = 1'b0;
    step();
    mem_ack_i = 1'b1;
    #1;
    check("post_rst_ack0", p0_ack_o, 1'b0);
    check("post_rst_ack1", p1_ack_o, 1'b0);
    step();
    mem_ack_i = 1'b0;
    check("post_rst_cnt0", p0_count_o, 16'd0);

    // Saturation on the 4-bit-counter instance.
    p0_enable_i = 1'b1; p0_addr_i = 32'h40;
    for (int i = 0; i < 15; i++) txn(1'b0, 32'h40, 0);
    check("sat_small_15", s_p0_count_o, 4'hF);
    check("sat_wide_15", p0_count_o, 16'd15);
    p0_enable_i = 1'b1;
    txn(1'b0, 32'h40, 0);
    p0_enable_i = 1'b0;
    check("sat_small_hold", s_p0_count_o, 4'hF);
    check("sat_wide_16", p0_count_o, 16'd16);
    check("sat_small_cnt1", s_p1_count_o, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single off-chip data memory port between the instruction cache (port 0) and the data cache (port 1). Each requester issues a 256-bit line read or write with the same enable/write/ack handshake the memory uses. The arbiter latches the winning request, drives the memory for the full transaction, and routes the acknowledge back to the owner. It also keeps per-port saturating transaction counters for performance monitoring.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 256, cache line / memory data width
- CNT_W, 16, width of per-port transaction counters

Ports:
- clk_i  in  1  system clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- p0_enable_i  in  1  port 0 request; held until p0_ack_o seen
- p0_write_i  in  1  port 0: 1 = write line, 0 = read line
- p0_addr_i  in  ADDR_W  port 0 line address
- p0_data_i  in  DATA_W  port 0 write data
- p0_ack_o  out  1  port 0 transaction complete (one cycle)
- p0_data_o  out  DATA_W  port 0 read data, valid when p0_ack_o=1
- p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o: same as port 0, for port 1
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- mem_data_i  in  DATA_W  memory read data
- mem_ack_i  in  1  memory completion, one cycle
- p0_count_o  out  CNT_W  completed port 0 transactions, saturating
- p1_count_o  out  CNT_W  completed port 1 transactions, saturating

## Operation
- States: IDLE, GRANT0, GRANT1. Register rr_last (1 bit) holds the last port granted.
- IDLE:
  - No enable asserted: stay in IDLE.
  - Exactly one enable asserted: grant that port.
  - Both asserted: grant the port not equal to rr_last.
- On a grant edge:
  - Capture that port's write/addr/data into mem_write_o/mem_addr_o/mem_data_o.
  - Set mem_enable_o=1, set rr_last to the granted port, enter GRANTn.
- GRANTn:
  - Memory outputs are held from registers. Requester inputs are ignored, so a requester dropping its enable mid-transaction does not abort the memory access.
  - pn_ack_o = mem_ack_i (combinational). The other port's ack is 0.
  - On an edge with mem_ack_i=1: mem_enable_o←0, mem_write_o←0, increment pn_count_o unless at all-ones, return to IDLE.
- p0_data_o and p1_data_o both carry mem_data_i continuously. They are meaningful only with the matching ack.
- mem_ack_i in IDLE is ignored: no ack forwarded, no counter change.
- mem_addr_o and mem_data_o keep their last values in IDLE. Only mem_enable_o and mem_write_o are cleared.
- Reset values: state=IDLE, rr_last=1 (port 0 wins the first contention), mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, counters=0, both acks=0.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight memory access is abandoned, and a later mem_ack_i is ignored.

## Timing
- Grant latency: enable seen at edge k, mem_enable_o high after edge k. Requests from IDLE therefore take one cycle to reach memory.
- Ack latency: zero. pn_ack_o rises in the same cycle as mem_ack_i.
- mem_enable_o drops on the edge that samples mem_ack_i. It stays low for at least one full cycle between transactions, because the next grant occurs from IDLE.
- Back-to-back from one port (e.g. D-cache writeback then refill with enable held high): second grant on the edge after the ack edge, if the other port is not requesting.
- Under continuous contention, grants strictly alternate 0,1,0,1…. Worst-case wait is one foreign transaction plus 2 cycles.
- Write data and address must be stable at the grant edge only.

## Test plan
- Reset, then port 0 read at 0x0000_0400, memory acks 10 cycles after mem_enable_o → mem_enable_o high one cycle after request, mem_write_o=0, mem_addr_o=0x400, p0_ack_o pulses with mem_ack_i, p0_data_o=mem_data_i, p0_count_o=1, p1_ack_o never 1.
- Both ports request in the same cycle after reset → port 0 granted first, then port 1 after port 0's ack plus one IDLE cycle. Over 4 held transactions each, order is 0,1,0,1,…, and final counts are 4/4.
- Port 1 write 0x0000_1A20 with data 0xDEAD…BEEF, then port 1 drops enable two cycles into GRANT1 → mem outputs unchanged until mem_ack_i, p1_ack_o still pulses, p1_count_o increments.
- mem_ack_i pulsed while IDLE → no ack outputs, counters unchanged, state stays IDLE.
- Assert rst_i during GRANT0 while mem_enable_o=1 → outputs zero asynchronously, counters zero. A mem_ack_i after release produces no ack.
- Preload port 0 to 0xFFFF (force or 65535 transactions), then complete one more → count stays 0xFFFF.
